// File: rtl/neuron_integrator_if.sv
// Axon beat and tick-result bundle between the sweep driver
// and one neuron integrator.
interface neuron_integrator_if #(
  parameter int POT_WIDTH   = 9,
  parameter int NUM_WEIGHTS = 4
);
  localparam int TW = (NUM_WEIGHTS > 1) ? $clog2(NUM_WEIGHTS) : 1;

  logic                        start;
  logic                        axon_valid;
  logic                        axon_spike;
  logic [TW-1:0]               axon_type;
  logic                        connection;
  logic                        busy;
  logic                        done;
  logic                        spike_out;
  logic signed [POT_WIDTH-1:0] potential;

  modport master (
    output start, axon_valid, axon_spike, axon_type, connection,
    input  busy, done, spike_out, potential
  );

  modport slave (
    input  start, axon_valid, axon_spike, axon_type, connection,
    output busy, done, spike_out, potential
  );
endinterface

// File: rtl/neuron_integrator.sv
// RANC neuron: integrates typed weights over one axon sweep,
// then applies leak, threshold, fire and reset once per tick.
module neuron_integrator #(
  parameter int NUM_AXONS    = 256,
  parameter int POT_WIDTH    = 9,
  parameter int WEIGHT_WIDTH = 9,
  parameter int NUM_WEIGHTS  = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  neuron_integrator_if.slave                  bus,
  input  logic [NUM_WEIGHTS*WEIGHT_WIDTH-1:0] weights,
  input  logic signed [WEIGHT_WIDTH-1:0]      leak,
  input  logic signed [POT_WIDTH-1:0]         pos_threshold,
  input  logic signed [POT_WIDTH-1:0]         neg_threshold,
  input  logic signed [POT_WIDTH-1:0]         reset_potential
);
  localparam int CW = $clog2(NUM_AXONS) + 1;
  localparam int SW =
    ((POT_WIDTH > WEIGHT_WIDTH) ? POT_WIDTH : WEIGHT_WIDTH) + 1;
  localparam logic signed [SW-1:0] P_MAX =
    SW'((2 ** (POT_WIDTH - 1)) - 1);
  localparam logic signed [SW-1:0] P_MIN = ~P_MAX;

  typedef enum logic [1:0] {
    S_IDLE,
    S_INTEG,
    S_LEAK,
    S_FIRE
  } state_t;

  state_t                        r_state;
  logic [CW-1:0]                 r_cnt;
  logic signed [POT_WIDTH-1:0]   r_pot;
  logic                          r_busy;
  logic                          r_done;
  logic                          r_spike;

  logic signed [WEIGHT_WIDTH-1:0] w_weight;
  logic signed [WEIGHT_WIDTH-1:0] w_addend;
  logic signed [POT_WIDTH-1:0]    w_sat;
  logic                           w_hit;

  function automatic logic signed [POT_WIDTH-1:0] sat_add(
    input logic signed [POT_WIDTH-1:0]    a,
    input logic signed [WEIGHT_WIDTH-1:0] b
  );
    logic signed [SW-1:0] s;
    s = {{(SW-POT_WIDTH){a[POT_WIDTH-1]}}, a}
      + {{(SW-WEIGHT_WIDTH){b[WEIGHT_WIDTH-1]}}, b};
    if (s > P_MAX) return P_MAX[POT_WIDTH-1:0];
    else if (s < P_MIN) return P_MIN[POT_WIDTH-1:0];
    else return s[POT_WIDTH-1:0];
  endfunction

  always_comb begin
    w_weight = weights[bus.axon_type*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    w_addend = (r_state == S_LEAK) ? leak : w_weight;
    w_sat    = sat_add(r_pot, w_addend);
    w_hit    = bus.axon_valid & bus.axon_spike & bus.connection;
  end

  // The done cycle already sits in IDLE; r_done gates out a start there.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_pot   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_spike <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_done  <= 1'b0;
          r_spike <= 1'b0;
          if (bus.start && !r_done) begin
            r_state <= S_INTEG;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_INTEG: begin
          if (bus.axon_valid) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_hit) r_pot <= w_sat;
            if (r_cnt == CW'(NUM_AXONS - 1)) r_state <= S_LEAK;
          end
        end
        S_LEAK: begin
          r_pot   <= w_sat;
          r_state <= S_FIRE;
        end
        S_FIRE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          if (r_pot >= pos_threshold) begin
            r_pot   <= reset_potential;
            r_spike <= 1'b1;
          end else if (r_pot < neg_threshold) begin
            r_pot <= neg_threshold;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.spike_out = r_spike;
  assign bus.potential = r_pot;
endmodule

// File: tb/tb_neuron_integrator.sv
// Bench for neuron_integrator: vector table, hand sequences
// and random ticks against a tick-level reference model.
module tb_neuron_integrator;
  localparam int NA = 256;
  localparam int PW = 9;
  localparam int WW = 9;
  localparam int NW = 4;
  localparam int PHI = (1 << (PW - 1)) - 1;
  localparam int PLO = -(1 << (PW - 1));

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  neuron_integrator_if #(.POT_WIDTH(PW), .NUM_WEIGHTS(NW)) bus ();

  logic [NW*WW-1:0]       weights;
  logic signed [WW-1:0]   leak;
  logic signed [PW-1:0]   pos_th;
  logic signed [PW-1:0]   neg_th;
  logic signed [PW-1:0]   rst_pot;

  neuron_integrator #(
    .NUM_AXONS(NA), .POT_WIDTH(PW),
    .WEIGHT_WIDTH(WW), .NUM_WEIGHTS(NW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .weights(weights),
    .leak(leak),
    .pos_threshold(pos_th),
    .neg_threshold(neg_th),
    .reset_potential(rst_pot)
  );

  int nerr = 0;
  int nchk = 0;

  bit b_spk [NA];
  bit b_conn[NA];
  int b_typ [NA];
  int wv    [NW];

  typedef struct {
    bit    do_rst;
    int    w;
    int    typ;
    int    nh;
    int    lk;
    int    pos;
    int    neg;
    int    rp;
    int    gap;
    int    exp_pot;
    bit    exp_spk;
    string nm;
  } vec_t;

  vec_t tv[9];

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int clampp(input int x);
    if (x > PHI) return PHI;
    if (x < PLO) return PLO;
    return x;
  endfunction

  function automatic void model(
    inout int p, output bit spk,
    input int lk, input int pos, input int neg, input int rp
  );
    spk = 1'b0;
    for (int i = 0; i < NA; i++)
      if (b_spk[i] && b_conn[i]) p = clampp(p + wv[b_typ[i]]);
    p = clampp(p + lk);
    if (p >= pos) begin
      p = rp;
      spk = 1'b1;
    end else if (p < neg) begin
      p = neg;
    end
  endfunction

  task automatic set_cfg(input int lk, input int pos,
                         input int neg, input int rp);
    for (int k = 0; k < NW; k++) weights[k*WW +: WW] = WW'(wv[k]);
    leak    = WW'(lk);
    pos_th  = PW'(pos);
    neg_th  = PW'(neg);
    rst_pot = PW'(rp);
  endtask

  task automatic fill_hits(input int nh, input int typ);
    for (int i = 0; i < NA; i++) begin
      if (i < nh) begin
        b_spk[i] = 1'b1; b_conn[i] = 1'b1; b_typ[i] = typ;
      end else begin
        int r;
        r = int'($urandom_range(0, 2));
        b_spk[i]  = (r == 1);
        b_conn[i] = (r == 2);
        b_typ[i]  = int'($urandom_range(0, NW - 1));
      end
    end
  endtask

  task automatic do_rst();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic run_tick(input string nm, input int exp_pot,
                          input bit exp_spk, input int maxgap);
    bit early, stray, spk;
    int at, nd, pot;
    early = 0; stray = 0; spk = 0; at = 0; nd = 0; pot = 0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk({nm, "_busy"}, int'(bus.busy), 1);
    for (int i = 0; i < NA; i++) begin
      int g;
      g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
      for (int j = 0; j < g; j++) begin
        bus.axon_valid = 1'b0;
        bus.axon_spike = 1'b1;
        bus.connection = 1'b1;
        bus.axon_type  = 2'($urandom);
        bus.start      = 1'($urandom);
        @(posedge clk); #1;
        if (bus.done) early = 1;
      end
      bus.axon_valid = 1'b1;
      bus.axon_spike = b_spk[i];
      bus.connection = b_conn[i];
      bus.axon_type  = 2'(b_typ[i]);
      bus.start      = 1'($urandom);
      @(posedge clk); #1;
      if (bus.done) early = 1;
      if (i == NA - 2) begin
        bus.axon_valid = 1'b0;
        bus.start      = 1'b0;
        repeat (3) begin
          @(posedge clk); #1;
          if (bus.done) early = 1;
        end
        chk({nm, "_stall_busy"}, int'(bus.busy), 1);
      end
    end
    bus.axon_valid = 1'b0;
    bus.axon_spike = 1'b0;
    bus.connection = 1'b0;
    bus.start      = 1'b0;
    chk({nm, "_early_done"}, int'(early), 0);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        nd++;
        if (at == 0) begin
          at  = k;
          spk = bus.spike_out;
          pot = int'($signed(bus.potential));
        end
      end else if (bus.spike_out) begin
        stray = 1;
      end
    end
    chk({nm, "_done_lat"}, at, 2);
    chk({nm, "_done_cnt"}, nd, 1);
    chk({nm, "_spike"}, int'(spk), int'(exp_spk));
    chk({nm, "_pot"}, pot, exp_pot);
    chk({nm, "_stray_spk"}, int'(stray), 0);
    chk({nm, "_idle"}, int'(bus.busy), 0);
  endtask

  initial begin
    int mp;
    bit ms;

    tv[0] = '{1'b1,   5, 0,   3,  -1,  20, -256,  0, 0,   14, 1'b0, "accum"};
    tv[1] = '{1'b1,  10, 1,   3,   0,  30, -256,  0, 0,    0, 1'b1, "fire"};
    tv[2] = '{1'b0,  10, 1,   0,   0,  30, -256,  0, 0,    0, 1'b0, "idle"};
    tv[3] = '{1'b1, 127, 2, 256, -10, 250, -256,  0, 0,  245, 1'b0, "sat"};
    tv[4] = '{1'b1, -50, 3,  10,   0, 100, -100,  0, 0, -100, 1'b0, "floor"};
    tv[5] = '{1'b0,   5, 0,   4,   0, 100, -256,  0, 2,  -80, 1'b0, "persist"};
    tv[6] = '{1'b1,  20, 1,   5,   3, 100, -256, -7, 1,   -7, 1'b1, "rpot"};
    tv[7] = '{1'b1,  33, 0,   3,   0, 100, -256,  0, 0,   99, 1'b0, "below_th"};
    tv[8] = '{1'b1, -10, 2,   5,   0, 100,  -50,  0, 0,  -50, 1'b0, "at_floor"};

    rst = 1'b1;
    bus.start = 1'b1;
    bus.axon_valid = 1'b0;
    bus.axon_spike = 1'b0;
    bus.axon_type = '0;
    bus.connection = 1'b0;
    for (int k = 0; k < NW; k++) wv[k] = 0;
    set_cfg(0, 100, -256, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pot", int'($signed(bus.potential)), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_spike", int'(bus.spike_out), 0);
    rst = 1'b0;
    bus.start = 1'b0;
    @(posedge clk); #1;

    for (int t = 0; t < 9; t++) begin
      if (tv[t].do_rst) do_rst();
      for (int k = 0; k < NW; k++) wv[k] = int'($urandom_range(0, 60)) - 30;
      wv[tv[t].typ] = tv[t].w;
      set_cfg(tv[t].lk, tv[t].pos, tv[t].neg, tv[t].rp);
      fill_hits(tv[t].nh, tv[t].typ);
      run_tick(tv[t].nm, tv[t].exp_pot, tv[t].exp_spk, tv[t].gap);
    end

    // start held through FIRE and done, then accepted one cycle later
    do_rst();
    wv[0] = 5;
    set_cfg(0, 255, -256, 0);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < NA; i++) begin
      bus.axon_valid = 1'b1;
      bus.axon_spike = 1'b0;
      bus.connection = 1'b1;
      bus.axon_type  = 2'd0;
      @(posedge clk); #1;
    end
    bus.axon_valid = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    chk("sd_done", int'(bus.done), 1);
    @(posedge clk); #1;
    chk("sd_ignored_busy", int'(bus.busy), 0);
    chk("sd_ignored_done", int'(bus.done), 0);
    @(posedge clk); #1;
    chk("sd_accept_busy", int'(bus.busy), 1);
    bus.start = 1'b0;

    for (int i = 0; i < 100; i++) begin
      bus.axon_valid = 1'b1;
      bus.axon_spike = 1'b1;
      bus.connection = 1'b1;
      bus.axon_type  = 2'd0;
      @(posedge clk); #1;
    end
    bus.axon_valid = 1'b0;
    chk("abort_mid_pot", int'($signed(bus.potential)), 255);
    do_rst();
    chk("abort_pot", int'($signed(bus.potential)), 0);
    chk("abort_busy", int'(bus.busy), 0);
    begin
      int nd;
      nd = 0;
      bus.axon_valid = 1'b1;
      bus.axon_spike = 1'b1;
      bus.connection = 1'b1;
      repeat (5) begin
        @(posedge clk); #1;
        if (bus.done) nd++;
      end
      bus.axon_valid = 1'b0;
      chk("abort_no_done", nd, 0);
      chk("idle_valid_pot", int'($signed(bus.potential)), 0);
    end
    fill_hits(3, 0);
    run_tick("restart", 15, 1'b0, 3);

    do_rst();
    mp = 0;
    for (int t = 0; t < 8; t++) begin
      int lk, pos, neg, rp;
      for (int k = 0; k < NW; k++) wv[k] = int'($urandom_range(0, 511)) - 256;
      lk  = int'($urandom_range(0, 80)) - 40;
      pos = int'($urandom_range(0, 300)) - 50;
      neg = int'($urandom_range(0, 236)) - 256;
      rp  = int'($urandom_range(0, 200)) - 100;
      set_cfg(lk, pos, neg, rp);
      for (int i = 0; i < NA; i++) begin
        b_spk[i]  = 1'($urandom);
        b_conn[i] = 1'($urandom);
        b_typ[i]  = int'($urandom_range(0, NW - 1));
      end
      model(mp, ms, lk, pos, neg, rp);
      run_tick($sformatf("rand%0d", t), mp, ms, 1);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
